// File: rtl/filt_n.sv
// filt_n: multi-channel glitch filter with hysteresis.
// Each channel's output changes only after the (optionally synchronised)
// input has held the opposite level for a run-time programmable number of
// consecutive clocks. Rise and fall lengths are independent. Bypass mode
// passes the synchronised input straight through.
module filt_n #(
    parameter int unsigned CH          = 4,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             byp,
    input  logic [CNT_W-1:0] rise_len,
    input  logic [CNT_W-1:0] fall_len,
    input  logic [CH-1:0]    i,
    output logic [CH-1:0]    y,
    output logic [CH-1:0]    rise,
    output logic [CH-1:0]    fall
);

    localparam int unsigned CW1 = CNT_W + 1;

    typedef enum logic [1:0] {
        LO    = 2'd0,
        LO2HI = 2'd1,
        HI    = 2'd2,
        HI2LO = 2'd3
    } state_t;

    logic [CH-1:0]    s;
    logic [CNT_W-1:0] thr_r;
    logic [CNT_W-1:0] thr_f;

    state_t           state_q [CH];
    state_t           state_d [CH];
    logic [CNT_W-1:0] cnt_q   [CH];
    logic [CNT_W-1:0] cnt_d   [CH];
    logic [CH-1:0]    y_d;
    logic [CH-1:0]    rise_d;
    logic [CH-1:0]    fall_d;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = i;
        end else begin : g_sync
            logic [CH-1:0] sync_q [SYNC_STAGES];

            // Input synchroniser shift chain, one per channel bit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= '0;
                    end
                end else begin
                    sync_q[0] <= i;
                    for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // A length of zero behaves as one
    assign thr_r = (rise_len == '0) ? CNT_W'(1) : rise_len;
    assign thr_f = (fall_len == '0) ? CNT_W'(1) : fall_len;

    // True when one more matching sample reaches the threshold; widened so cnt+1 cannot wrap
    function automatic logic reached(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] thr);
        return (CW1'(cnt) + CW1'(1)) >= CW1'(thr);
    endfunction

    // Per-channel next-state, counter and output decode
    always_comb begin
        for (int unsigned c = 0; c < CH; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            y_d[c]     = y[c];
            rise_d[c]  = 1'b0;
            fall_d[c]  = 1'b0;

            if (byp) begin
                state_d[c] = s[c] ? HI : LO;
                cnt_d[c]   = '0;
                y_d[c]     = s[c];
                rise_d[c]  = s[c] & ~y[c];
                fall_d[c]  = ~s[c] & y[c];
            end else begin
                case (state_q[c])
                    LO: begin
                        if (s[c]) begin
                            if (thr_r == CNT_W'(1)) begin
                                state_d[c] = HI;
                                cnt_d[c]   = '0;
                                y_d[c]     = 1'b1;
                                rise_d[c]  = 1'b1;
                            end else begin
                                state_d[c] = LO2HI;
                                cnt_d[c]   = CNT_W'(1);
                            end
                        end
                    end
                    LO2HI: begin
                        if (s[c]) begin
                            if (reached(cnt_q[c], thr_r)) begin
                                state_d[c] = HI;
                                cnt_d[c]   = '0;
                                y_d[c]     = 1'b1;
                                rise_d[c]  = 1'b1;
                            end else begin
                                cnt_d[c] = cnt_q[c] + CNT_W'(1);
                            end
                        end else begin
                            state_d[c] = LO;
                            cnt_d[c]   = '0;
                        end
                    end
                    HI: begin
                        if (!s[c]) begin
                            if (thr_f == CNT_W'(1)) begin
                                state_d[c] = LO;
                                cnt_d[c]   = '0;
                                y_d[c]     = 1'b0;
                                fall_d[c]  = 1'b1;
                            end else begin
                                state_d[c] = HI2LO;
                                cnt_d[c]   = CNT_W'(1);
                            end
                        end
                    end
                    HI2LO: begin
                        if (!s[c]) begin
                            if (reached(cnt_q[c], thr_f)) begin
                                state_d[c] = LO;
                                cnt_d[c]   = '0;
                                y_d[c]     = 1'b0;
                                fall_d[c]  = 1'b1;
                            end else begin
                                cnt_d[c] = cnt_q[c] + CNT_W'(1);
                            end
                        end else begin
                            state_d[c] = HI;
                            cnt_d[c]   = '0;
                        end
                    end
                    default: begin
                        state_d[c] = LO;
                        cnt_d[c]   = '0;
                        y_d[c]     = 1'b0;
                    end
                endcase
            end
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < CH; c++) begin
                state_q[c] <= LO;
                cnt_q[c]   <= '0;
            end
            y    <= '0;
            rise <= '0;
            fall <= '0;
        end else begin
            for (int unsigned c = 0; c < CH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            y    <= y_d;
            rise <= rise_d;
            fall <= fall_d;
        end
    end

endmodule

// File: tb/tb_filt_n.sv
// Testbench for filt_n: directed vector table, hand sequences for the
// multi-cycle corners, and a randomized run against a run-length model.
`timescale 1ns/1ps
module tb_filt_n;

    localparam int unsigned CH    = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned SYNC  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             byp = 1'b0;
    logic [CNT_W-1:0] rise_len = '0;
    logic [CNT_W-1:0] fall_len = '0;
    logic [CH-1:0]    i = '0;
    logic [CH-1:0]    y;
    logic [CH-1:0]    rise;
    logic [CH-1:0]    fall;

    int n_cmp = 0;
    int n_bad = 0;

    filt_n #(.CH(CH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .byp(byp),
        .rise_len(rise_len), .fall_len(fall_len),
        .i(i), .y(y), .rise(rise), .fall(fall)
    );

    always #5 clk = ~clk;

    // Reference: a delay line for the synchroniser plus, per channel, the
    // length of the current run of samples that disagree with y.
    logic [CH-1:0] m_dly [4];
    logic [CH-1:0] m_y = '0;
    logic [CH-1:0] m_rise = '0;
    logic [CH-1:0] m_fall = '0;
    logic [CH-1:0] m_s;
    int            m_run [CH];
    int            m_tr;
    int            m_tf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) m_dly[k] = '0;
            for (int c = 0; c < int'(CH); c++) m_run[c] = 0;
            m_y = '0; m_rise = '0; m_fall = '0;
        end else begin
            m_s  = (SYNC == 0) ? i : m_dly[(SYNC == 0) ? 0 : SYNC - 1];
            m_tr = (rise_len == 0) ? 1 : int'(rise_len);
            m_tf = (fall_len == 0) ? 1 : int'(fall_len);
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < int'(CH); c++) begin
                if (byp) begin
                    if (m_s[c] != m_y[c]) begin
                        m_rise[c] = m_s[c];
                        m_fall[c] = ~m_s[c];
                    end
                    m_y[c]   = m_s[c];
                    m_run[c] = 0;
                end else if (m_s[c] != m_y[c]) begin
                    m_run[c]++;
                    if (m_run[c] >= (m_y[c] ? m_tf : m_tr)) begin
                        m_rise[c] = ~m_y[c];
                        m_fall[c] = m_y[c];
                        m_y[c]    = ~m_y[c];
                        m_run[c]  = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            for (int k = 3; k > 0; k--) m_dly[k] = m_dly[k-1];
            m_dly[0] = i;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i     = '0;
        byp   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [CNT_W-1:0] rlen;
        int               ones;
        int               exp_at;   // edge index of rise, -1 = no rise
    } vec_t;

    vec_t tbl [9];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int            at;
        int            npulse;
        logic [15:0]   pat;

        tbl[0] = '{4'd3,  10, 4};
        tbl[1] = '{4'd3,   3, 4};
        tbl[2] = '{4'd3,   2, -1};
        tbl[3] = '{4'd0,   1, 2};
        tbl[4] = '{4'd1,   1, 2};
        tbl[5] = '{4'd5,   4, -1};
        tbl[6] = '{4'd15, 15, 16};
        tbl[7] = '{4'd2,   6, 3};
        tbl[8] = '{4'd4,   4, 5};

        // Reset held with all inputs high
        rst_n = 1'b0; i = '1; rise_len = 4'd1; fall_len = 4'd1;
        #1;
        chk("rst_y_now", 32'(y), 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_y", 32'(y), 32'h0);
            chk("rst_pulses", 32'({rise, fall}), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_y", 32'(y), 32'hF);
        rst_n = 1'b0;
        #1;
        chk("async_rst_y", 32'(y), 32'h0);
        chk("async_rst_pulses", 32'({rise, fall}), 32'h0);

        // Vector table on channel 0
        for (int v = 0; v < 9; v++) begin
            do_reset();
            rise_len = tbl[v].rlen;
            fall_len = 4'd15;
            i[0]     = 1'b1;
            at = -1; npulse = 0;
            for (int e = 0; e < 24; e++) begin
                @(negedge clk);
                if (rise[0]) begin
                    npulse++;
                    if (at < 0) at = e;
                end
                if (e == tbl[v].ones - 1) i[0] = 1'b0;
            end
            chk($sformatf("tbl%0d_rise_edge", v), 32'(at), 32'(tbl[v].exp_at));
            chk($sformatf("tbl%0d_rise_count", v), 32'(npulse), (tbl[v].exp_at >= 0) ? 32'd1 : 32'd0);
            chk($sformatf("tbl%0d_other_ch", v), 32'(y[3:1]), 32'h0);
        end

        // Fall glitch on channel 1: 3 lows with fall_len=4 must not drop y
        do_reset();
        rise_len = 4'd1; fall_len = 4'd4;
        i[1] = 1'b1;
        repeat (5) @(negedge clk);
        chk("fglitch_y_hi", 32'(y[1]), 32'h1);
        i[1] = 1'b0;
        npulse = 0;
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            if (fall[1] || !y[1]) npulse++;
            if (e == 2) i[1] = 1'b1;
        end
        chk("fglitch_no_fall", 32'(npulse), 32'h0);

        // Four lows qualify the fall
        i[1] = 1'b0;
        at = -1; npulse = 0;
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            if (fall[1]) begin
                npulse++;
                if (at < 0) at = e;
            end
            if (e == 3) i[1] = 1'b1;
        end
        chk("fall4_edge", 32'(at), 32'd5);
        chk("fall4_count", 32'(npulse), 32'd1);

        // Lowering rise_len mid-count on channel 2
        do_reset();
        rise_len = 4'd8; fall_len = 4'd15;
        i[2] = 1'b1;
        at = -1;
        for (int e = 0; e < 13; e++) begin
            @(negedge clk);
            if (rise[2] && at < 0) at = e;
            if (e == 6) rise_len = 4'd4;
        end
        chk("midcount_rise_edge", 32'(at), 32'd7);

        // Zero lengths on channel 3: y tracks input two edges late plus one
        do_reset();
        rise_len = 4'd0; fall_len = 4'd0;
        pat = 16'($urandom);
        i[3] = pat[0];
        for (int e = 0; e < 16; e++) begin
            @(negedge clk);
            if (e >= 3) begin
                chk($sformatf("zlen_y_e%0d", e), 32'(y[3]), 32'(pat[e-2]));
                chk($sformatf("zlen_pulse_e%0d", e), 32'({rise[3], fall[3]}),
                    32'({pat[e-2] & ~pat[e-3], ~pat[e-2] & pat[e-3]}));
            end
            if (e < 15) i[3] = pat[e+1];
        end

        // Randomized run against the reference model
        do_reset();
        rise_len = 4'd2; fall_len = 4'd3;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            chk("rnd_y", 32'(y), 32'(m_y));
            chk("rnd_rise", 32'(rise), 32'(m_rise));
            chk("rnd_fall", 32'(fall), 32'(m_fall));
            rst_n = 1'b1;
            for (int c = 0; c < int'(CH); c++)
                if ($urandom_range(0, 3) == 0) i[c] = ~i[c];
            if ($urandom_range(0, 29) == 0) byp = ~byp;
            if ($urandom_range(0, 39) == 0) rise_len = CNT_W'($urandom_range(0, 6));
            if ($urandom_range(0, 39) == 0) fall_len = CNT_W'($urandom_range(0, 6));
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("rnd_async_rst_y", 32'(y), 32'(m_y));
                chk("rnd_async_rst_pulse", 32'({rise, fall}), 32'({m_rise, m_fall}));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
